// File: rtl/serial_cfg_tx.sv
// Serial configuration transmitter: shifts a parallel word out on sclk/sdin
// with a start/busy/done handshake; every output is a flop.
module serial_cfg_tx #(
    parameter int unsigned DATA_W    = 5,
    parameter int unsigned HALF      = 2,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic              i_clk,
    input  logic              i_resetbALL,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sclk,
    output logic              o_sdin
);

    localparam int unsigned PH_W  = ($clog2(HALF) < 1) ? 1 : $clog2(HALF);
    localparam int unsigned BIT_W = ($clog2(DATA_W) < 1) ? 1 : $clog2(DATA_W);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    generate
        if (HALF < 2 || HALF > 255) begin : g_bad_half
            $error("serial_cfg_tx: HALF must be in 2..255");
        end
        if (DATA_W < 1) begin : g_bad_width
            $error("serial_cfg_tx: DATA_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_STOP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sclk_q, sclk_d;
    logic               sdin_q, sdin_d;

    // State, counters and output registers.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sdin_q  <= sdin_d;
        end
    end

    // Next state; outputs are derived from the next state so they line up
    // with the state register in the same cycle.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    shift_d = i_data;
                    bit_d   = '0;
                    phase_d = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = S_HIGH;
                end else begin
                    phase_d = PH_W'(phase_q + 1'b1);
                end
            end
            S_HIGH: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = BIT_W'(bit_q + 1'b1);
                        shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
                        state_d = S_LOW;
                    end
                end else begin
                    phase_d = PH_W'(phase_q + 1'b1);
                end
            end
            S_STOP: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    phase_d = PH_W'(phase_q + 1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        sclk_d = (state_d == S_HIGH);
        sdin_d = 1'b0;
        if (state_d == S_LOW || state_d == S_HIGH) begin
            sdin_d = (LSB_FIRST != 0) ? shift_d[0] : shift_d[DATA_W-1];
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_sclk = sclk_q;
    assign o_sdin = sdin_q;

endmodule

// File: tb/tb_serial_cfg_tx.sv
// Bench for serial_cfg_tx: four differently parameterised instances checked
// every cycle against a frame-timing model, plus directed spot checks.
module tb_serial_cfg_tx;

    localparam int NI = 4;

    function automatic int dw_of(int i);
        case (i)
            2:       return 1;
            3:       return 7;
            default: return 5;
        endcase
    endfunction

    function automatic int hf_of(int i);
        case (i)
            2:       return 4;
            3:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int lf_of(int i);
        case (i)
            1:       return 0;
            3:       return 0;
            default: return 1;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st  [NI];
    logic [7:0] dat [NI];
    logic       bsy [NI];
    logic       dn  [NI];
    logic       sck [NI];
    logic       sdi [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit         m_act [NI];
    int         m_s   [NI];
    logic [7:0] m_d   [NI];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int DWG = dw_of(g);
            localparam int HFG = hf_of(g);
            localparam int LFG = lf_of(g);
            serial_cfg_tx #(
                .DATA_W    (DWG),
                .HALF      (HFG),
                .LSB_FIRST (LFG)
            ) u_dut (
                .i_clk       (clk),
                .i_resetbALL (rst_n),
                .i_start     (st[g]),
                .i_data      (dat[g][DWG-1:0]),
                .o_busy      (bsy[g]),
                .o_done      (dn[g]),
                .o_sclk      (sck[g]),
                .o_sdin      (sdi[g])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame length in cycles from the accepted start to the done cycle.
    function automatic int frame_total(int i);
        return dw_of(i) * 2 * hf_of(i) + hf_of(i) + 1;
    endfunction

    function automatic bit model_idle(int i, int n);
        return !m_act[i] || ((n - m_s[i]) >= frame_total(i));
    endfunction

    // Expected {busy, done, sclk, sdin} in cycle n for instance i.
    function automatic logic [3:0] model_out(int i, int n);
        int dw, h, fl, rel, k, ph;
        logic [3:0] r;
        r  = 4'b0000;
        dw = dw_of(i);
        h  = hf_of(i);
        fl = dw * 2 * h;
        if (!m_act[i]) return r;
        rel = n - m_s[i];
        if (rel >= 1 && rel <= fl) begin
            k    = (rel - 1) / (2 * h);
            ph   = (rel - 1) % (2 * h);
            r[3] = 1'b1;
            r[1] = (ph >= h);
            r[0] = (lf_of(i) != 0) ? m_d[i][k] : m_d[i][dw-1-k];
        end else if (rel > fl && rel <= fl + h) begin
            r[3] = 1'b1;
        end else if (rel == fl + h + 1) begin
            r[2] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) m_act[i] <= 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (st[i] && model_idle(i, cyc)) begin
                    m_act[i] <= 1'b1;
                    m_s[i]   <= cyc;
                    m_d[i]   <= dat[i];
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        logic [3:0] e;
        for (int i = 0; i < NI; i++) begin
            e = model_out(i, cyc);
            check_eq($sformatf("busy[%0d]@%0d", i, cyc), 32'(bsy[i]), 32'(e[3]));
            check_eq($sformatf("done[%0d]@%0d", i, cyc), 32'(dn[i]),  32'(e[2]));
            check_eq($sformatf("sclk[%0d]@%0d", i, cyc), 32'(sck[i]), 32'(e[1]));
            check_eq($sformatf("sdin[%0d]@%0d", i, cyc), 32'(sdi[i]), 32'(e[0]));
        end
    end

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s_busy[%0d]", tag, i), 32'(bsy[i]), 32'd0);
            check_eq($sformatf("%s_sclk[%0d]", tag, i), 32'(sck[i]), 32'd0);
            check_eq($sformatf("%s_sdin[%0d]", tag, i), 32'(sdi[i]), 32'd0);
            check_eq($sformatf("%s_done[%0d]", tag, i), 32'(dn[i]),  32'd0);
        end
    endtask

    initial begin
        int c, t;
        logic [4:0] want_l, want_m;
        want_l = 5'b10110;  // index k: bit sent at the k-th rising edge, LSB first
        want_m = 5'b01101;  // same word, MSB first
        for (int i = 0; i < NI; i++) begin
            st[i]  = 1'b0;
            dat[i] = 8'h00;
        end

        repeat (3) @(negedge clk);
        #1 check_all_zero("in_reset");
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check_all_zero("post_reset");

        // Basic frame on all instances, with a busy-time start on instance 0.
        c = cyc;
        st[0] = 1'b1; dat[0] = 8'b10110;
        st[1] = 1'b1; dat[1] = 8'b10110;
        st[2] = 1'b1; dat[2] = 8'h01;
        st[3] = 1'b1; dat[3] = 8'($urandom);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            st[i]  = 1'b0;
            dat[i] = 8'($urandom);
        end
        dat[2] = 8'h00;
        while (cyc < c + 24) begin
            @(negedge clk);
            t = cyc - c;
            if (t == 10) begin st[0] = 1'b1; dat[0] = 8'h00; end
            if (t == 11) st[0] = 1'b0;
            check_eq($sformatf("basic_busy@%0d", t), 32'(bsy[0]), 32'(t <= 22));
            check_eq($sformatf("basic_done@%0d", t), 32'(dn[0]),  32'(t == 23));
            if (t >= 3 && t <= 19 && ((t - 3) % 4) == 0) begin
                check_eq($sformatf("basic_rise@%0d", t), 32'(sck[0]), 32'd1);
                check_eq($sformatf("lsb_bit@%0d", t), 32'(sdi[0]), 32'(want_l[(t-3)/4]));
                check_eq($sformatf("msb_bit@%0d", t), 32'(sdi[1]), 32'(want_m[(t-3)/4]));
            end
            check_eq($sformatf("w1_sclk@%0d", t), 32'(sck[2]), 32'(t >= 5 && t <= 8));
            check_eq($sformatf("w1_done@%0d", t), 32'(dn[2]),  32'(t == 13));
            if (t <= 8) check_eq($sformatf("w1_sdin@%0d", t), 32'(sdi[2]), 32'd1);
        end
        repeat (30) @(negedge clk);

        // Back-to-back frames with start held high.
        c = cyc;
        st[0] = 1'b1; dat[0] = 8'b10110;
        while (cyc < c + 48) begin
            @(negedge clk);
            t = cyc - c;
            if (t == 23) check_eq("b2b_done", 32'(dn[0]), 32'd1);
            if (t == 24) check_eq("b2b_low_busy", 32'(bsy[0]), 32'd1);
            if (t == 25) check_eq("b2b_low_sclk", 32'(sck[0]), 32'd0);
            if (t == 26) check_eq("b2b_rise", 32'(sck[0]), 32'd1);
        end
        st[0] = 1'b0;
        repeat (30) @(negedge clk);

        // Reset in the middle of a frame.
        c = cyc;
        st[0] = 1'b1; dat[0] = 8'b10110;
        @(negedge clk);
        st[0] = 1'b0;
        while (cyc < c + 9) @(negedge clk);
        check_eq("pre_rst_busy", 32'(bsy[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        st[0] = 1'b1; dat[0] = 8'b01011;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (30) @(negedge clk);

        // Randomised starts, data churn and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                st[i]  = (($urandom % 4) == 0);
                dat[i] = 8'($urandom);
            end
            if (($urandom % 400) == 0) begin
                #1 rst_n = 1'b0;
                #1 check_all_zero("rand_rst");
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end
        for (int i = 0; i < NI; i++) st[i] = 1'b0;
        repeat (60) @(negedge clk);
        check_all_zero("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
